// File: rtl/fmc_adc_serdes_sync.sv
// Frame-alignment controller for the LTC2174 deserialiser: bitslips the SERDES until the
// frame-clock word matches the expected pattern, then declares and monitors lock.
module fmc_adc_serdes_sync #(
    parameter logic [7:0]  g_FRAME_PATTERN = 8'h0F,
    parameter int unsigned g_SETTLE_CYCLES = 16,
    parameter int unsigned g_LOCK_COUNT    = 64,
    parameter int unsigned g_LOSS_COUNT    = 4,
    parameter int unsigned g_MAX_SLIPS     = 16
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       pll_locked_i,
    input  logic       resync_i,
    input  logic       frame_valid_i,
    input  logic [7:0] frame_i,
    output logic       bitslip_o,
    output logic       synced_o,
    output logic       fail_o,
    output logic [3:0] slip_count_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_SLIP,
        ST_LOCKED,
        ST_FAIL
    } state_t;

    localparam logic [7:0] SETTLE_LOAD = 8'(g_SETTLE_CYCLES);
    localparam logic [7:0] LOCK_LAST   = 8'(g_LOCK_COUNT - 1);
    localparam logic [3:0] LOSS_LAST   = 4'(g_LOSS_COUNT - 1);
    localparam logic [4:0] MAX_SLIPS   = 5'(g_MAX_SLIPS);

    state_t     state;
    logic [7:0] settle_cnt;
    logic [7:0] good_cnt;
    logic [3:0] bad_cnt;
    logic [4:0] attempt_cnt;
    logic       frame_good;
    logic       frame_bad;
    logic [4:0] attempt_next;

    assign frame_good   = frame_valid_i && (frame_i == g_FRAME_PATTERN);
    assign frame_bad    = frame_valid_i && (frame_i != g_FRAME_PATTERN);
    assign attempt_next = attempt_cnt + 5'd1;

    // Outputs are assigned alongside the state transition that implies them, so each one
    // is a flop that already reflects the state being entered.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            // NOTE: every flop here is a control register, so all of them take the async reset.
            state        <= ST_IDLE;
            settle_cnt   <= '0;
            good_cnt     <= '0;
            bad_cnt      <= '0;
            attempt_cnt  <= '0;
            bitslip_o    <= 1'b0;
            synced_o     <= 1'b0;
            fail_o       <= 1'b0;
            slip_count_o <= '0;
        end else begin
            // NOTE: non-blocking throughout; a default here keeps bitslip_o a one-cycle pulse.
            bitslip_o <= 1'b0;

            if (!pll_locked_i || resync_i) begin
                // PLL loss outranks a resync request; both wipe all progress.
                state        <= pll_locked_i ? ST_SETTLE : ST_IDLE;
                settle_cnt   <= pll_locked_i ? SETTLE_LOAD : 8'd0;
                good_cnt     <= '0;
                bad_cnt      <= '0;
                attempt_cnt  <= '0;
                synced_o     <= 1'b0;
                fail_o       <= 1'b0;
                slip_count_o <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state      <= ST_SETTLE;
                        settle_cnt <= SETTLE_LOAD;
                    end

                    ST_SETTLE: begin
                        settle_cnt <= settle_cnt - 8'd1;
                        if (settle_cnt <= 8'd1) begin
                            state    <= ST_CHECK;
                            good_cnt <= '0;
                        end
                    end

                    ST_CHECK: begin
                        if (frame_good) begin
                            if (good_cnt == LOCK_LAST) begin
                                state       <= ST_LOCKED;
                                synced_o    <= 1'b1;
                                bad_cnt     <= '0;
                                attempt_cnt <= '0;
                            end else begin
                                good_cnt <= good_cnt + 8'd1;
                            end
                        end else if (frame_bad) begin
                            state     <= ST_SLIP;
                            bitslip_o <= 1'b1;
                        end
                    end

                    ST_SLIP: begin
                        attempt_cnt <= attempt_next;
                        if (slip_count_o != 4'hF) begin
                            slip_count_o <= slip_count_o + 4'd1;
                        end
                        if (attempt_next >= MAX_SLIPS) begin
                            state  <= ST_FAIL;
                            fail_o <= 1'b1;
                        end else begin
                            state      <= ST_SETTLE;
                            settle_cnt <= SETTLE_LOAD;
                        end
                    end

                    ST_LOCKED: begin
                        if (frame_good) begin
                            bad_cnt <= '0;
                        end else if (frame_bad) begin
                            if (bad_cnt == LOSS_LAST) begin
                                state     <= ST_SLIP;
                                bitslip_o <= 1'b1;
                                synced_o  <= 1'b0;
                                bad_cnt   <= '0;
                            end else begin
                                bad_cnt <= bad_cnt + 4'd1;
                            end
                        end
                    end

                    ST_FAIL: begin
                        state <= ST_FAIL;
                    end

                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fmc_adc_serdes_sync.sv
// Directed bench for fmc_adc_serdes_sync: a table of {inputs, cycles, expected outputs}
// records plus a hand-written bitslip search against a rotating-word SERDES model.
module tb_fmc_adc_serdes_sync;

    typedef struct {
        string      name;
        logic       pll;
        logic       resync;
        logic       valid;
        logic [7:0] frame;
        int         cycles;
        logic       e_synced;
        logic       e_fail;
        logic       e_bitslip;
        int         e_slips;
        int         e_pulses;
    } vec_t;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       pll_locked_i;
    logic       resync_i;
    logic       frame_valid_i;
    logic [7:0] frame_i;
    logic       bitslip_o;
    logic       synced_o;
    logic       fail_o;
    logic [3:0] slip_count_o;

    int checks = 0;
    int errors = 0;

    // Pulse monitor: only observes the DUT, never drives.
    int pulse_total = 0;
    int min_gap     = 1000;
    int cyc         = 0;
    int last_pulse  = -1;

    vec_t tbl[$];

    fmc_adc_serdes_sync dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .pll_locked_i  (pll_locked_i),
        .resync_i      (resync_i),
        .frame_valid_i (frame_valid_i),
        .frame_i       (frame_i),
        .bitslip_o     (bitslip_o),
        .synced_o      (synced_o),
        .fail_o        (fail_o),
        .slip_count_o  (slip_count_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        cyc = cyc + 1;
        if (bitslip_o) begin
            if (last_pulse >= 0 && (cyc - last_pulse) < min_gap) min_gap = cyc - last_pulse;
            last_pulse  = cyc;
            pulse_total = pulse_total + 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance n rising edges; return just after the following falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk_i);
        #1;
    endtask

    function automatic logic [7:0] rotr(input logic [7:0] p, input int m);
        logic [15:0] t;
        t = {p, p} >> m;
        return t[7:0];
    endfunction

    function automatic void add(input string name, input logic pll, input logic resync,
                                input logic [7:0] frame, input int cycles, input logic es,
                                input logic ef, input logic eb, input int ec, input int ep);
        vec_t v;
        v.name = name; v.pll = pll; v.resync = resync; v.valid = 1'b1; v.frame = frame;
        v.cycles = cycles; v.e_synced = es; v.e_fail = ef; v.e_bitslip = eb;
        v.e_slips = ec; v.e_pulses = ep;
        tbl.push_back(v);
    endfunction

    task automatic apply(input vec_t v);
        pll_locked_i  = v.pll;
        resync_i      = v.resync;
        frame_valid_i = v.valid;
        frame_i       = v.frame;
        step(1);
        resync_i = 1'b0;
        if (v.cycles > 1) step(v.cycles - 1);
        check({v.name, ".synced"},  int'(synced_o),     int'(v.e_synced));
        check({v.name, ".fail"},    int'(fail_o),       int'(v.e_fail));
        check({v.name, ".bitslip"}, int'(bitslip_o),    int'(v.e_bitslip));
        check({v.name, ".slips"},   int'(slip_count_o), v.e_slips);
        check({v.name, ".pulses"},  pulse_total,        v.e_pulses);
    endtask

    initial begin
        int misalign;
        int found;
        int budget;

        //   name                pll rsy frame  cyc  sync fail bs  slips pulses
        add("clean_pre",         1, 0, 8'h0F,  80, 0, 0, 0,  0, 0);
        add("clean_lock",        1, 0, 8'h0F,   1, 1, 0, 0,  0, 0);
        add("bad3",              1, 0, 8'h00,   3, 1, 0, 0,  0, 0);
        add("good_clears",       1, 0, 8'h0F,   1, 1, 0, 0,  0, 0);
        add("bad3_again",        1, 0, 8'h00,   3, 1, 0, 0,  0, 0);
        add("bad4th_loss",       1, 0, 8'h00,   1, 0, 0, 1,  0, 1);
        add("slip_exit",         1, 0, 8'h0F,   1, 0, 0, 0,  1, 1);
        add("relock_pre",        1, 0, 8'h0F,  79, 0, 0, 0,  1, 1);
        add("relock",            1, 0, 8'h0F,   1, 1, 0, 0,  1, 1);
        add("pll_drop_locked",   0, 0, 8'h0F,   1, 0, 0, 0,  0, 1);
        add("pll_up",            1, 0, 8'h0F,   1, 0, 0, 0,  0, 1);
        add("settle_part",       1, 0, 8'h0F,   5, 0, 0, 0,  0, 1);
        add("pll_drop_settle",   0, 0, 8'h0F,   1, 0, 0, 0,  0, 1);
        add("pll_up2",           1, 0, 8'h0F,   1, 0, 0, 0,  0, 1);
        add("relock2_pre",       1, 0, 8'h0F,  79, 0, 0, 0,  0, 1);
        add("relock2",           1, 0, 8'h0F,   1, 1, 0, 0,  0, 1);
        add("resync_pll_drop",   0, 1, 8'h00,   1, 0, 0, 0,  0, 1);
        add("pll_up3",           1, 0, 8'h0F,   1, 0, 0, 0,  0, 1);
        add("relock3_pre",       1, 0, 8'h0F,  79, 0, 0, 0,  0, 1);
        add("relock3",           1, 0, 8'h0F,   1, 1, 0, 0,  0, 1);
        add("bad3_pre_resync",   1, 0, 8'h00,   3, 1, 0, 0,  0, 1);
        add("resync_vs_loss",    1, 1, 8'h00,   1, 0, 0, 0,  0, 1);
        add("resync_lock_pre",   1, 0, 8'h0F,  79, 0, 0, 0,  0, 1);
        add("resync_vs_lock",    1, 1, 8'h0F,   1, 0, 0, 0,  0, 1);
        add("relock4_pre",       1, 0, 8'h0F,  79, 0, 0, 0,  0, 1);
        add("relock4",           1, 0, 8'h0F,   1, 1, 0, 0,  0, 1);
        add("fail_resync",       1, 1, 8'h55,   1, 0, 0, 0,  0, 1);
        add("fail_settle",       1, 0, 8'h55,  16, 0, 0, 0,  0, 1);
        add("fail_first_slip",   1, 0, 8'h55,   1, 0, 0, 1,  0, 2);
        add("fail_slip_exit",    1, 0, 8'h55,   1, 0, 0, 0,  1, 2);
        add("fail_16th_slip",    1, 0, 8'h55, 269, 0, 0, 1, 15, 17);
        add("fail_entered",      1, 0, 8'h55,   1, 0, 1, 0, 15, 17);
        add("fail_sticky",       1, 0, 8'h55, 100, 0, 1, 0, 15, 17);
        add("fail_clear",        1, 1, 8'h0F,   1, 0, 0, 0,  0, 17);
        add("fail_relock_pre",   1, 0, 8'h0F,  79, 0, 0, 0,  0, 17);
        add("fail_relock",       1, 0, 8'h0F,   1, 1, 0, 0,  0, 17);

        rst_n_i       = 1'b0;
        pll_locked_i  = 1'b1;
        resync_i      = 1'b0;
        frame_valid_i = 1'b1;
        frame_i       = 8'h0F;
        step(1);
        check("reset.synced",  int'(synced_o),     0);
        check("reset.fail",    int'(fail_o),       0);
        check("reset.bitslip", int'(bitslip_o),    0);
        check("reset.slips",   int'(slip_count_o), 0);
        rst_n_i = 1'b1;

        foreach (tbl[i]) apply(tbl[i]);

        // Bitslip search: the SERDES word starts 3 bits off; each pulse shifts it one bit back.
        misalign = 3;
        found    = 0;
        budget   = 0;
        frame_i  = rotr(8'h0F, misalign);
        resync_i = 1'b1;
        step(1);
        resync_i = 1'b0;
        while (!synced_o && budget < 400) begin
            step(1);
            budget = budget + 1;
            if (bitslip_o) begin
                found    = found + 1;
                misalign = (misalign + 7) % 8;
                frame_i  = rotr(8'h0F, misalign);
            end
        end
        check("search.synced",  int'(synced_o),     1);
        check("search.pulses",  found,              3);
        check("search.slips",   int'(slip_count_o), 3);
        check("search.fail",    int'(fail_o),       0);

        step(5);
        check("total.pulses",  pulse_total,          20);
        check("pulse.min_gap", int'(min_gap >= 17),  1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
